// File: rtl/rf_path_sequencer_pkg.sv
// Purpose : shared mode/state encodings and RF path table for the path sequencer.
// Latency : n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
package rf_path_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_RX09 = 2'b01,
    MODE_RX24 = 2'b10,
    MODE_TX   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHDN   = 3'd1,
    S_SWITCH = 3'd2,
    S_FLUSH  = 3'd3,
    S_ENABLE = 3'd4,
    S_ACTIVE = 3'd5
  } state_e;

  // Front-end switch word, ordered {rx_h_tx_l, tr_vc1, tr_vc2}.
  typedef struct packed {
    logic rx_h_tx_l;
    logic tr_vc1;
    logic tr_vc2;
  } path_t;

  localparam path_t PATH_IDLE = 3'b100;
  localparam path_t PATH_RX09 = 3'b110;
  localparam path_t PATH_RX24 = 3'b101;
  localparam path_t PATH_TX   = 3'b000;

  function automatic path_t path_of(input mode_e m);
    path_t p;
    case (m)
      MODE_RX09: p = PATH_RX09;
      MODE_RX24: p = PATH_RX24;
      MODE_TX:   p = PATH_TX;
      default:   p = PATH_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rf_path_sequencer_timer.sv
// Purpose : loadable down-counter shared by the settle and flush waits (rf_seq_timer).
// Latency : o_done is high once the count reaches 0; load N-1 for an N-cycle wait.
// Backpressure: none; a load always wins over the decrement.
// Ports   : i_clk/i_rst_b clock and async active-low reset; i_load/i_load_val
//           start a new wait; o_done flags an expired (zero) count.
module rf_seq_timer #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/rf_path_sequencer.sv
// Purpose : break-before-make sequencing of RF front-end switches, LNAs, mixer and FIFO flush.
// Latency : 1+SETTLE+FLUSH+SETTLE cycles accept->ready (1+SETTLE to IDLE); same-mode request is a no-op.
// Backpressure: o_mode_req_ready low while sequencing; requests seen then are dropped, not queued.
// Ports   : i_mode_req/_valid/o_mode_req_ready request handshake; o_mode_active/o_busy status;
//           o_channel RX mux select; o_fifo_flush FIFO reset; front-end pin drives
//           (o_rx_h_tx_l, o_tr_vc1/2, o_shdn_*_lna, o_mixer_en); i_tx_fifo_empty/o_wdog_trip watchdog.
// Option  : define RF_SEQ_WDOG_EN to enable the TX-underrun watchdog (WDOG_CYCLES).
module rf_path_sequencer
  import rf_path_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int FLUSH_CYCLES  = 4,
  parameter int WDOG_CYCLES   = 65535
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic [1:0] i_mode_req,
  input  logic       i_mode_req_valid,
  output logic       o_mode_req_ready,
  output logic [1:0] o_mode_active,
  output logic       o_busy,
  output logic       o_channel,
  output logic       o_fifo_flush,
  input  logic       i_tx_fifo_empty,
  output logic       o_rx_h_tx_l,
  output logic       o_tr_vc1,
  output logic       o_tr_vc2,
  output logic       o_shdn_rx_lna,
  output logic       o_shdn_tx_lna,
  output logic       o_mixer_en,
  output logic       o_wdog_trip
);

  localparam int TMR_MAX = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);

  state_e       state_q,       state_d;
  mode_e        target_q,      target_d;
  mode_e        mode_active_q, mode_active_d;
  path_t        path_q,        path_d;
  logic         ready_q,       ready_d;
  logic         busy_q,        busy_d;
  logic         channel_q,     channel_d;
  logic         flush_q,       flush_d;
  logic         shdn_rx_q,     shdn_rx_d;
  logic         shdn_tx_q,     shdn_tx_d;
  logic         mixer_q,       mixer_d;
  logic         wdog_trip_q,   wdog_trip_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          wdog_hit;

  rf_seq_timer #(.W(TW)) u_timer (
    .i_clk      (i_sys_clk),
    .i_rst_b    (i_rst_b),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done)
  );

`ifdef RF_SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_armed;

  // Only an established TX mode is watched; any other state keeps the count at 0.
  assign wdog_armed = (state_q == S_ACTIVE) && (mode_active_q == MODE_TX) && i_tx_fifo_empty;
  assign wdog_hit   = wdog_armed && (wdog_cnt_q == WW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_cnt_d = '0;
    if (wdog_armed && !wdog_hit) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic wdog_unused;
  assign wdog_hit    = 1'b0;
  assign wdog_unused = ^{i_tx_fifo_empty, 32'(WDOG_CYCLES)};
`endif

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    mode_active_d = mode_active_q;
    path_d        = path_q;
    ready_d       = ready_q;
    busy_d        = busy_q;
    channel_d     = channel_q;
    flush_d       = flush_q;
    shdn_rx_d     = shdn_rx_q;
    shdn_tx_d     = shdn_tx_q;
    mixer_d       = mixer_q;
    wdog_trip_d   = wdog_hit;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    case (state_q)
      S_IDLE, S_ACTIVE: begin
        // A watchdog abort behaves like an internal IDLE request and beats a host request.
        if (wdog_hit) begin
          target_d = MODE_IDLE;
          state_d  = S_SHDN;
        end else if (i_mode_req_valid && ready_q) begin
          target_d = mode_e'(i_mode_req);
          if (mode_e'(i_mode_req) != mode_active_q) begin
            state_d = S_SHDN;
          end
        end
        if (state_d == S_SHDN) begin
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          shdn_rx_d = 1'b1;
          shdn_tx_d = 1'b1;
          mixer_d   = 1'b0;
        end
      end

      S_SHDN: begin
        // LNAs and mixer are already off; the path may now move.
        state_d  = S_SWITCH;
        path_d   = path_of(target_q);
        tmr_load = 1'b1;
        tmr_val  = TW'(SETTLE_CYCLES - 1);
        if (target_q == MODE_RX24) begin
          channel_d = 1'b1;
        end else if (target_q == MODE_RX09) begin
          channel_d = 1'b0;
        end
      end

      S_SWITCH: begin
        if (tmr_done) begin
          if (target_q == MODE_IDLE) begin
            state_d       = S_IDLE;
            mode_active_d = MODE_IDLE;
            ready_d       = 1'b1;
            busy_d        = 1'b0;
          end else begin
            state_d  = S_FLUSH;
            flush_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(FLUSH_CYCLES - 1);
          end
        end
      end

      S_FLUSH: begin
        if (tmr_done) begin
          state_d  = S_ENABLE;
          flush_d  = 1'b0;
          mixer_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE_CYCLES - 1);
          if (target_q == MODE_TX) begin
            shdn_tx_d = 1'b0;
          end else begin
            shdn_rx_d = 1'b0;
          end
        end
      end

      S_ENABLE: begin
        if (tmr_done) begin
          state_d       = S_ACTIVE;
          mode_active_d = target_q;
          ready_d       = 1'b1;
          busy_d        = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q       <= S_IDLE;
      target_q      <= MODE_IDLE;
      mode_active_q <= MODE_IDLE;
      path_q        <= PATH_IDLE;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      channel_q     <= 1'b0;
      flush_q       <= 1'b0;
      shdn_rx_q     <= 1'b1;
      shdn_tx_q     <= 1'b1;
      mixer_q       <= 1'b0;
      wdog_trip_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      mode_active_q <= mode_active_d;
      path_q        <= path_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      channel_q     <= channel_d;
      flush_q       <= flush_d;
      shdn_rx_q     <= shdn_rx_d;
      shdn_tx_q     <= shdn_tx_d;
      mixer_q       <= mixer_d;
      wdog_trip_q   <= wdog_trip_d;
    end
  end

  assign o_mode_req_ready = ready_q;
  assign o_mode_active    = mode_active_q;
  assign o_busy           = busy_q;
  assign o_channel        = channel_q;
  assign o_fifo_flush     = flush_q;
  assign o_rx_h_tx_l      = path_q.rx_h_tx_l;
  assign o_tr_vc1         = path_q.tr_vc1;
  assign o_tr_vc2         = path_q.tr_vc2;
  assign o_shdn_rx_lna    = shdn_rx_q;
  assign o_shdn_tx_lna    = shdn_tx_q;
  assign o_mixer_en       = mixer_q;
  assign o_wdog_trip      = wdog_trip_q;

endmodule

// File: tb/tb_rf_path_sequencer.sv
module tb_rf_path_sequencer;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [1:0] mode_req = 2'b00;
  logic       mode_req_valid = 1'b0;
  logic       tx_empty = 1'b0;
  logic       ready, busy, channel, flush, rx_h_tx_l, vc1, vc2;
  logic       shdn_rx, shdn_tx, mixer, trip;
  logic [1:0] mode_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef RF_SEQ_WDOG_EN
  localparam int WDOG = 8;
  localparam int EXP_TRIPS = 1;
  localparam int EXP_FIRST = 8;
  localparam logic [1:0] EXP_WD_MODE = 2'b00;
`else
  localparam int WDOG = 65535;
  localparam int EXP_TRIPS = 0;
  localparam int EXP_FIRST = -1;
  localparam logic [1:0] EXP_WD_MODE = 2'b11;
`endif

  rf_path_sequencer #(
    .SETTLE_CYCLES (16),
    .FLUSH_CYCLES  (4),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .i_sys_clk        (clk),
    .i_rst_b          (rst_b),
    .i_mode_req       (mode_req),
    .i_mode_req_valid (mode_req_valid),
    .o_mode_req_ready (ready),
    .o_mode_active    (mode_active),
    .o_busy           (busy),
    .o_channel        (channel),
    .o_fifo_flush     (flush),
    .i_tx_fifo_empty  (tx_empty),
    .o_rx_h_tx_l      (rx_h_tx_l),
    .o_tr_vc1         (vc1),
    .o_tr_vc2         (vc2),
    .o_shdn_rx_lna    (shdn_rx),
    .o_shdn_tx_lna    (shdn_tx),
    .o_mixer_en       (mixer),
    .o_wdog_trip      (trip)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {ready,busy,mode_active,channel,flush,path[2:0],shdn_rx,shdn_tx,mixer,trip}
  localparam logic [12:0] RST_VEC = 13'b1_0_00_0_0_100_1_1_0_0;
  function automatic logic [12:0] out_vec();
    return {ready, busy, mode_active, channel, flush, rx_h_tx_l, vc1, vc2,
            shdn_rx, shdn_tx, mixer, trip};
  endfunction

  // Safety properties sampled every cycle while out of reset.
  logic [2:0] prev_path = 3'b100;
  always @(negedge clk) begin
    if (!rst_b) begin
      prev_path <= 3'b100;
    end else begin
      check("both_lna_on", {shdn_rx, shdn_tx} == 2'b00, 0);
      check("busy_vs_ready", busy, !ready);
      if ({rx_h_tx_l, vc1, vc2} != prev_path)
        check("lna_on_at_path_change", {shdn_rx, shdn_tx, mixer}, 3'b110);
      if (flush)
        check("lna_on_in_flush", {shdn_rx, shdn_tx, mixer}, 3'b110);
      prev_path <= {rx_h_tx_l, vc1, vc2};
    end
  end

  // Issue one request, then measure ready-low cycles and flush-high cycles.
  task automatic do_req(input logic [1:0] req, output int lat, output int fl);
    bit done;
    @(negedge clk);
    mode_req       = req;
    mode_req_valid = 1'b1;
    @(posedge clk);
    #1 mode_req_valid = 1'b0;
    lat  = 0;
    fl   = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (flush) fl++;
      if (ready) done = 1;
      else lat++;
    end
    if (!done) check("ready_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] mode;
    logic       ch;
    logic [2:0] path;
    logic       srx, stx, mix;
    int         lat;
    int         fl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, fl, trips, first;

    vecs[0] = '{2'b01, 2'b01, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 37, 4}; // RX09 from reset
    vecs[1] = '{2'b01, 2'b01, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1,  0, 0}; // same mode: no-op
    vecs[2] = '{2'b11, 2'b11, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 37, 4}; // RX09 -> TX
    vecs[3] = '{2'b10, 2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 37, 4}; // TX -> RX24
    vecs[4] = '{2'b00, 2'b00, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 17, 0}; // to IDLE, channel holds
    vecs[5] = '{2'b10, 2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 37, 4};
    vecs[6] = '{2'b11, 2'b11, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 37, 4}; // TX keeps channel
    vecs[7] = '{2'b00, 2'b00, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 17, 0};

    // Reset state, held and after release.
    #12;
    check("reset_held", out_vec(), RST_VEC);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("reset_release", out_vec(), RST_VEC);

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].req, lat, fl);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_flush_cycles", i), fl, vecs[i].fl);
      check($sformatf("v%0d_mode", i), mode_active, vecs[i].mode);
      check($sformatf("v%0d_channel", i), channel, vecs[i].ch);
      check($sformatf("v%0d_path", i), {rx_h_tx_l, vc1, vc2}, vecs[i].path);
      check($sformatf("v%0d_lna_mix", i), {shdn_rx, shdn_tx, mixer},
            {vecs[i].srx, vecs[i].stx, vecs[i].mix});
    end

    // RX24 request, then an RX09 request held while busy must be dropped.
    @(negedge clk);
    mode_req       = 2'b10;
    mode_req_valid = 1'b1;
    @(negedge clk);
    check("busy_after_accept", {ready, busy}, 2'b01);
    mode_req = 2'b01;
    repeat (10) @(negedge clk);
    mode_req_valid = 1'b0;
    lat = 11;
    for (int c = 0; c < 200 && !ready; c++) begin
      @(negedge clk);
      if (!ready) lat++;
    end
    check("busy_ignore_latency", lat, 37);
    check("busy_ignore_mode", mode_active, 2'b10);
    check("busy_ignore_channel", channel, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_ignore_no_retrigger", ready, 1'b1);

    // Reset asserted while flushing: flush and everything else drop at once.
    @(negedge clk);
    mode_req       = 2'b11;
    mode_req_valid = 1'b1;
    @(posedge clk);
    #1 mode_req_valid = 1'b0;
    for (int c = 0; c < 100 && !flush; c++) @(negedge clk);
    check("reached_flush", flush, 1'b1);
    rst_b = 1'b0;
    #1;
    check("mid_reset_values", out_vec(), RST_VEC);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("post_mid_reset_values", out_vec(), RST_VEC);

    // Watchdog: TX active with the FIFO held empty.
    do_req(2'b11, lat, fl);
    check("wd_tx_latency", lat, 37);
    tx_empty = 1'b1;
    trips = 0;
    first = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (trip) begin
        trips++;
        if (first < 0) first = c;
      end
    end
    tx_empty = 1'b0;
    check("wd_trip_count", trips, EXP_TRIPS);
    check("wd_trip_cycle", first, EXP_FIRST);
    check("wd_final_mode", mode_active, EXP_WD_MODE);
    check("wd_final_ready", ready, 1'b1);

    // Empty toggling every 5 cycles never reaches the limit.
    if (mode_active != 2'b11) begin
      do_req(2'b11, lat, fl);
      check("wd_retx_latency", lat, 37);
    end
    trips = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) tx_empty = ~tx_empty;
      @(negedge clk);
      if (trip) trips++;
    end
    tx_empty = 1'b0;
    check("wd_toggle_no_trip", trips, 0);
    check("wd_toggle_mode", mode_active, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
